// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address field helpers for the data cache.
// Field helpers take the geometry as arguments so parameter overrides stay consistent.
package dcache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StWrite
  } state_e;

  localparam int unsigned DEF_INDEX_BITS = 10;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned OFF_BITS       = $clog2(DEF_LINE_WORDS);
  localparam int unsigned TAG_BITS       = 32 - 2 - OFF_BITS - DEF_INDEX_BITS;

  function automatic logic [31:0] addr_offset(logic [31:0] addr, int unsigned off_bits);
    return (addr >> 2) & ((32'd1 << off_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(logic [31:0] addr, int unsigned off_bits,
                                             int unsigned index_bits);
    return (addr >> (off_bits + 32'd2)) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(logic [31:0] addr, int unsigned off_bits,
                                           int unsigned index_bits);
    return addr >> (off_bits + index_bits + 32'd2);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Pipeline request port and main-memory port of the data cache, bundled together.
// The cache takes the slave view; the pipeline/memory environment takes the master view.
interface dcache_if;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_array.sv
// Valid bits, tag RAM and word-addressed data RAM of a direct-mapped cache.
// Reads and the hit compare are combinational; a single index serves reads and writes.
module dcache_array #(
  parameter int unsigned INDEX_BITS = 10,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned OffW = $clog2(LINE_WORDS),
  localparam int unsigned TagW = 30 - OffW - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] i_index,
  input  logic [OffW-1:0]       i_rd_offset,
  input  logic [TagW-1:0]       i_tag,
  output logic [31:0]           o_rd_data,
  output logic                  o_hit,
  input  logic                  i_data_we,
  input  logic [OffW-1:0]       i_wr_offset,
  input  logic [31:0]           i_wr_data,
  input  logic                  i_fill
);

  localparam int unsigned Lines = 1 << INDEX_BITS;

  logic [Lines-1:0] r_valid;
  logic [TagW-1:0]  r_tag  [Lines];
  logic [31:0]      r_data [Lines*LINE_WORDS];

  logic [INDEX_BITS+OffW-1:0] w_rd_ptr;
  logic [INDEX_BITS+OffW-1:0] w_wr_ptr;

  assign w_rd_ptr  = {i_index, i_rd_offset};
  assign w_wr_ptr  = {i_index, i_wr_offset};
  assign o_rd_data = r_data[w_rd_ptr];
  assign o_hit     = r_valid[i_index] && (r_tag[i_index] == i_tag);

  // Clearing the valid bits wins over a fill landing on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_fill) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_fill) begin
      r_tag[i_index] <= i_tag;
    end
    if (i_data_we) begin
      r_data[w_wr_ptr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Serves load hits combinationally and stalls for line refills and every store.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input logic      clk,
  input logic      rst_n,
  dcache_if.slave  io_bus
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned TagW = 30 - OffW - INDEX_BITS;

  state_e          r_state, w_state_nxt;
  logic [OffW-1:0] r_count, w_count_nxt;
  logic [31:0]     r_addr, w_addr_nxt;
  logic [31:0]     r_wdata, w_wdata_nxt;

  logic [31:0]           w_lookup_addr;
  logic [INDEX_BITS-1:0] w_index;
  logic [OffW-1:0]       w_rd_off;
  logic [TagW-1:0]       w_tag;
  logic [31:0]           w_rd_data;
  logic                  w_hit;
  logic                  w_data_we;
  logic [OffW-1:0]       w_wr_off;
  logic [31:0]           w_wr_data;
  logic                  w_fill;

  logic        w_stall, w_mem_req, w_mem_we;
  logic [31:0] w_rdata, w_mem_addr, w_mem_wdata;

  // New requests are only looked up in IDLE; otherwise the latched address owns the array.
  assign w_lookup_addr = (r_state == StIdle) ? io_bus.req_addr : r_addr;
  assign w_index  = INDEX_BITS'(addr_index(w_lookup_addr, OffW, INDEX_BITS));
  assign w_rd_off = OffW'(addr_offset(w_lookup_addr, OffW));
  assign w_tag    = TagW'(addr_tag(w_lookup_addr, OffW, INDEX_BITS));

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_index     (w_index),
    .i_rd_offset (w_rd_off),
    .i_tag       (w_tag),
    .o_rd_data   (w_rd_data),
    .o_hit       (w_hit),
    .i_data_we   (w_data_we),
    .i_wr_offset (w_wr_off),
    .i_wr_data   (w_wr_data),
    .i_fill      (w_fill)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_stall     = 1'b0;
    w_rdata     = '0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_data_we   = 1'b0;
    w_wr_off    = r_count;
    w_wr_data   = io_bus.mem_rdata;
    w_fill      = 1'b0;
    case (r_state)
      StIdle: begin
        if (io_bus.req_valid) begin
          if (io_bus.req_we) begin
            w_stall     = 1'b1;
            w_addr_nxt  = {io_bus.req_addr[31:2], 2'b00};
            w_wdata_nxt = io_bus.req_wdata;
            w_state_nxt = StWrite;
          end else if (w_hit) begin
            w_rdata = w_rd_data;
          end else begin
            w_stall     = 1'b1;
            w_addr_nxt  = {io_bus.req_addr[31:OffW+2], {(OffW+2){1'b0}}};
            w_count_nxt = '0;
            w_state_nxt = StRefill;
          end
        end
      end
      StRefill: begin
        w_stall    = 1'b1;
        w_mem_req  = 1'b1;
        w_mem_addr = {r_addr[31:OffW+2], r_count, 2'b00};
        if (io_bus.mem_ready) begin
          w_data_we   = 1'b1;
          w_count_nxt = r_count + OffW'(1);
          if (r_count == OffW'(LINE_WORDS - 1)) begin
            w_fill      = 1'b1;
            w_state_nxt = StIdle;
          end
        end
      end
      StWrite: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
        w_stall     = !io_bus.mem_ready;
        if (io_bus.mem_ready) begin
          w_data_we   = w_hit;
          w_wr_off    = w_rd_off;
          w_wr_data   = r_wdata;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_count <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  assign io_bus.stall     = w_stall;
  assign io_bus.rdata     = w_rdata;
  assign io_bus.mem_req   = w_mem_req;
  assign io_bus.mem_we    = w_mem_we;
  assign io_bus.mem_addr  = w_mem_addr;
  assign io_bus.mem_wdata = w_mem_wdata;

endmodule
